hazard_scoreboard_unit: RTL and testbench
=========================================

Name: hazard_scoreboard_unit

Overview:
- Parametrised load-use/multi-cycle hazard controller for the 5-stage RISC-V pipeline.
- Keeps a per-register countdown scoreboard of in-flight results that cannot yet be forwarded.
- Stalls the decode-stage instruction until its operands are forwardable and enforces write-after-write (WAW) ordering.
- Handles a taken-branch flush and counts stall cycles; sits beside the ID stage and drives PC, IF/ID and ID/EX control.

Parameters:
- NUM_REGS, 32, architectural register count.
- REG_AW, 5, register index width (2^REG_AW >= NUM_REGS).
- LOAD_LAT, 1, cycles after issue before a load result is forwardable (1..7).
- MUL_LAT, 3, cycles after issue before a multiply result is forwardable (1..7).
- CNT_W, 16, stall counter width.
- ZERO_HARDWIRED, 1, when 1, register 0 is never tracked and never causes a hazard.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  source register indices.
- id_rs1_used, id_rs2_used  in  1  source actually read.
- id_rd  in  REG_AW  destination index.
- id_rd_write  in  1  instruction writes id_rd.
- id_op_class  in  2  0=ALU, 1=LOAD, 2=MUL, 3=treated as ALU.
- ex_branch_taken  in  1  taken branch/jump resolved in EX; flush request.
- stall  out  1  hold the ID instruction this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register write enable.
- idex_bubble  out  1  insert NOP into ID/EX.
- ifid_flush  out  1  clear IF/ID.
- pending_any  out  1  some scoreboard counter is nonzero.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State:
  - cnt[r] for r in 0..NUM_REGS-1; width ceil(log2(max(LOAD_LAT,MUL_LAT)+1)).
  - stall_count.
  - Everything else is combinational from state and inputs.
- Class latency L: ALU/class 3 = 0, LOAD = LOAD_LAT, MUL = MUL_LAT.
- Tracking masks:
  - rsN_haz = id_rsN_used && cnt[id_rsN] != 0 && !(ZERO_HARDWIRED && id_rsN == 0).
  - waw = id_rd_write && cnt[id_rd] > L && !(ZERO_HARDWIRED && id_rd == 0).
- hazard = id_valid && (rs1_haz || rs2_haz || waw).
- Flush has priority:
  - stall = hazard && !ex_branch_taken.
  - ifid_flush = ex_branch_taken.
  - idex_bubble = stall || ex_branch_taken.
  - pc_write = ifid_write = !stall.
- issue = id_valid && !stall && !ex_branch_taken.
- Each rising edge, for every r:
  - If issue && id_rd_write && id_rd == r && L != 0 && !(ZERO_HARDWIRED && r == 0): cnt[r] <= L.
  - Else if cnt[r] != 0: cnt[r] <= cnt[r] - 1.
  - Else hold 0.
  - A newly issued entry is loaded, not decremented, in its issue cycle.
- Issuing an ALU write (L=0) to a register with a pending count is impossible, since waw stalls until cnt == 0; no overwrite case exists.
- A stalled or flushed ID instruction never updates the scoreboard.
- stall_count: +1 on each edge where stall=1; saturates at 2^CNT_W-1.
- pending_any = OR of all cnt != 0.
- Load-use timing:
  - Load issued in cycle t with LOAD_LAT=1: a dependent instruction in ID at t+1 stalls exactly one cycle and proceeds at t+2.
  - In general, a dependent at distance d stalls max(0, L-d+1) cycles.
- Reset:
  - Asynchronous; clears all cnt and stall_count immediately, including mid-stall.
  - While cleared: stall=0, pc_write=1, ifid_write=1, pending_any=0.
  - idex_bubble and ifid_flush follow ex_branch_taken.
- Out-of-range indices (>= NUM_REGS) read as cnt=0 and are never written.

Test Plan:
- LOAD_LAT=1: load x5, next cycle add x6,x5,x1 -> one cycle stall=1, pc_write=0, ifid_write=0, idex_bubble=1; next cycle stall=0; stall_count=1.
- MUL_LAT=3: mul x7 then dependent next -> 3 stall cycles. With one independent instruction between -> 2 stall cycles. stall_count totals 5.
- Load writing x0, then instruction using rs1=x0 -> no stall, pending_any stays 0.
- Dependent on pending load held in ID with ex_branch_taken=1 -> stall=0, ifid_flush=1, idex_bubble=1, pc_write=1. Its rd is not recorded (pending_any follows only the older load).
- WAW: mul x3 (cnt=3), next cycle load x3 (L=1) with no source use -> stalls 1 cycle (cnt 2 > 1), issues when cnt=1, cnt[3] reloads to 1, then 0.
- Assert reset mid-way through a 3-cycle MUL stall -> stall drops to 0 immediately, pending_any=0, stall_count=0. After release, the same dependent issues without stalling.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// Load-use / multi-cycle hazard controller for the ID stage of a 5-stage RISC-V pipeline.
// Per-register countdown scoreboard; stalls on RAW/WAW, flush wins over stall, saturating stall counter.
module hazard_scoreboard_unit #(
  parameter int NUM_REGS       = 32,
  parameter int REG_AW         = 5,
  parameter int LOAD_LAT       = 1,
  parameter int MUL_LAT        = 3,
  parameter int CNT_W          = 16,
  parameter int ZERO_HARDWIRED = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_write,
  input  logic [1:0]        id_op_class,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              pending_any,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int MAX_LAT = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] LOAD_L = CW'(LOAD_LAT);
  localparam logic [CW-1:0] MUL_L  = CW'(MUL_LAT);

  logic [CW-1:0]          lat;
  logic [NUM_REGS-1:0]    rs1_sel;
  logic [NUM_REGS-1:0]    rs2_sel;
  logic [NUM_REGS-1:0]    rd_sel;
  logic [NUM_REGS-1:0]    pend;
  logic [NUM_REGS*CW-1:0] cnt_flat;
  logic [CW-1:0]          rs1_cnt;
  logic [CW-1:0]          rs2_cnt;
  logic [CW-1:0]          rd_cnt;
  logic                   rs1_zero;
  logic                   rs2_zero;
  logic                   rd_zero;
  logic                   rs1_haz;
  logic                   rs2_haz;
  logic                   waw;
  logic                   hazard;
  logic                   issue;
  logic [CNT_W-1:0]       sc_q;
  logic [CNT_W-1:0]       sc_d;

  always_comb begin
    case (id_op_class)
      2'd1:    lat = LOAD_L;
      2'd2:    lat = MUL_L;
      default: lat = '0;
    endcase
  end

  // Decoded selects never match indices >= NUM_REGS, so those read as zero and are never written.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam bit TRACKED = !((ZERO_HARDWIRED != 0) && (gi == 0));
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      assign rs1_sel[gi] = (id_rs1 == REG_AW'(gi));
      assign rs2_sel[gi] = (id_rs2 == REG_AW'(gi));
      assign rd_sel[gi]  = (id_rd  == REG_AW'(gi));

      always_comb begin
        cnt_d = cnt_q;
        if (TRACKED && issue && id_rd_write && rd_sel[gi] && (lat != '0))
          cnt_d = lat;
        else if (cnt_q != '0)
          cnt_d = cnt_q - CW'(1);
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end

      assign cnt_flat[gi*CW +: CW] = cnt_q;
      assign pend[gi]              = |cnt_q;
    end
  endgenerate

  always_comb begin
    rs1_cnt = '0;
    rs2_cnt = '0;
    rd_cnt  = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rs1_sel[r]) rs1_cnt = cnt_flat[r*CW +: CW];
      if (rs2_sel[r]) rs2_cnt = cnt_flat[r*CW +: CW];
      if (rd_sel[r])  rd_cnt  = cnt_flat[r*CW +: CW];
    end
  end

  assign rs1_zero = (ZERO_HARDWIRED != 0) && (id_rs1 == '0);
  assign rs2_zero = (ZERO_HARDWIRED != 0) && (id_rs2 == '0);
  assign rd_zero  = (ZERO_HARDWIRED != 0) && (id_rd  == '0);

  assign rs1_haz = id_rs1_used && (rs1_cnt != '0) && !rs1_zero;
  assign rs2_haz = id_rs2_used && (rs2_cnt != '0) && !rs2_zero;
  // A younger writer may only issue once its result cannot land before the older one.
  assign waw     = id_rd_write && (rd_cnt > lat) && !rd_zero;
  assign hazard  = id_valid && (rs1_haz || rs2_haz || waw);

  assign stall       = hazard && !ex_branch_taken;
  assign ifid_flush  = ex_branch_taken;
  assign idex_bubble = stall || ex_branch_taken;
  assign pc_write    = !stall;
  assign ifid_write  = !stall;
  assign issue       = id_valid && !stall && !ex_branch_taken;
  assign pending_any = |pend;

  always_comb begin
    sc_d = sc_q;
    if (stall && (sc_q != '1)) sc_d = sc_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sc_q <= '0;
    else       sc_q <= sc_d;
  end

  assign stall_count = sc_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: load-use, MUL distances, x0, flush, WAW and async reset.
`timescale 1ns/1ps
module tb_hazard_scoreboard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_rd_write;
  logic [1:0]  id_op_class;
  logic        ex_branch_taken;
  logic        stall, pc_write, ifid_write, idex_bubble, ifid_flush, pending_any;
  logic [15:0] stall_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(
    .NUM_REGS(32), .REG_AW(5), .LOAD_LAT(1), .MUL_LAT(3), .CNT_W(16), .ZERO_HARDWIRED(1)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_write(id_rd_write), .id_op_class(id_op_class),
    .ex_branch_taken(ex_branch_taken), .stall(stall), .pc_write(pc_write),
    .ifid_write(ifid_write), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .pending_any(pending_any), .stall_count(stall_count)
  );

  // Applies one ID-stage instruction on the falling edge, settles, then leaves it for the next rising edge.
  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic [1:0] cls, input logic br);
    @(negedge clk);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_rd_write = wr; id_op_class = cls; ex_branch_taken = br;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1; id_rs2 = 5'd0; id_rs2_used = 1'b0;
    id_rd = 5'd6; id_rd_write = 1'b1; id_op_class = 2'd0; ex_branch_taken = 1'b1;
    #1;
    vectors++;
    if ({stall, pc_write, ifid_write, pending_any} !== 4'b0110) begin
      miscompares++;
      $display("FAIL reset_ctrl: got stall/pcw/ifw/pend=%b want 0110", {stall, pc_write, ifid_write, pending_any});
    end
    vectors++;
    if ({idex_bubble, ifid_flush} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_flush: got bubble/flush=%b want 11", {idex_bubble, ifid_flush});
    end
    vectors++;
    if (stall_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_count: got %0d want 0", stall_count);
    end
    @(negedge clk);
    reset = 1'b0;
    idle();
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    pulse_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd1, 1'b0);       // lw x5
    drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 2'd0, 1'b0);       // add x6,x5,x1
    vectors++;
    if ({stall, pc_write, ifid_write, idex_bubble} !== 4'b1001) begin
      miscompares++;
      $display("FAIL load_use_stall: got stall/pcw/ifw/bubble=%b want 1001", {stall, pc_write, ifid_write, idex_bubble});
    end
    drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 2'd0, 1'b0);
    vectors++;
    if ({stall, idex_bubble} !== 2'b00) begin
      miscompares++;
      $display("FAIL load_use_release: got stall/bubble=%b want 00", {stall, idex_bubble});
    end
    vectors++;
    if (stall_count !== 16'd1) begin
      miscompares++;
      $display("FAIL load_use_count: got %0d want 1", stall_count);
    end
    // Distance two from the load: no stall expected.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd1, 1'b0);
    drive(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 2'd0, 1'b0);
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 2'd3, 1'b0);
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL load_dist2: got stall=%b want 0", stall);
    end
    idle();
    $display("test_load_use done");
  endtask

  task automatic test_mul();
    int stalls;
    pulse_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd2, 1'b0);       // mul x7
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 2'd0, 1'b0);
      if (!stall) break;
      stalls++;
    end
    vectors++;
    if (stalls !== 3) begin
      miscompares++;
      $display("FAIL mul_dist1: got %0d stall cycles want 3", stalls);
    end
    idle();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd2, 1'b0);
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 2'd0, 1'b0);       // independent
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_indep: got stall=%b want 0", stall);
    end
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 2'd0, 1'b0);
      if (!stall) break;
      stalls++;
    end
    vectors++;
    if (stalls !== 2) begin
      miscompares++;
      $display("FAIL mul_dist2: got %0d stall cycles want 2", stalls);
    end
    vectors++;
    if (stall_count !== 16'd5) begin
      miscompares++;
      $display("FAIL mul_count: got %0d want 5", stall_count);
    end
    idle();
    $display("test_mul done");
  endtask

  task automatic test_x0();
    pulse_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'd1, 1'b0);       // lw x0
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 2'd0, 1'b0);
    vectors++;
    if ({stall, pending_any} !== 2'b00) begin
      miscompares++;
      $display("FAIL x0_use: got stall/pend=%b want 00", {stall, pending_any});
    end
    idle();
    $display("test_x0 done");
  endtask

  task automatic test_flush();
    pulse_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd1, 1'b0);       // lw x5
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 2'd2, 1'b1);      // dependent mul x10, flushed
    vectors++;
    if ({stall, ifid_flush, idex_bubble, pc_write, ifid_write} !== 5'b01111) begin
      miscompares++;
      $display("FAIL flush_ctrl: got stall/flush/bubble/pcw/ifw=%b want 01111",
               {stall, ifid_flush, idex_bubble, pc_write, ifid_write});
    end
    vectors++;
    if (pending_any !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_pend_load: got %b want 1", pending_any);
    end
    idle();
    vectors++;
    if (pending_any !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_not_recorded: got pending_any=%b want 0", pending_any);
    end
    vectors++;
    if (stall_count !== 16'd0) begin
      miscompares++;
      $display("FAIL flush_count: got %0d want 0", stall_count);
    end
    $display("test_flush done");
  endtask

  task automatic test_waw();
    pulse_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'd2, 1'b0);       // mul x3 -> cnt 3
    idle();                                                            // cnt 3 -> 2
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'd1, 1'b0);       // lw x3 sees cnt 2
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL waw_stall: got stall=%b want 1", stall);
    end
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'd1, 1'b0);       // cnt 1, issues
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL waw_issue: got stall=%b want 0", stall);
    end
    idle();
    vectors++;
    if (pending_any !== 1'b1) begin
      miscompares++;
      $display("FAIL waw_reload: got pending_any=%b want 1", pending_any);
    end
    idle();
    vectors++;
    if (pending_any !== 1'b0) begin
      miscompares++;
      $display("FAIL waw_drain: got pending_any=%b want 0", pending_any);
    end
    $display("test_waw done");
  endtask

  task automatic test_reset_mid_stall();
    pulse_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd2, 1'b0);       // mul x7
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 2'd0, 1'b0);
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 2'd0, 1'b0);
    vectors++;
    if ({stall, stall_count} !== {1'b1, 16'd1}) begin
      miscompares++;
      $display("FAIL mid_stall_pre: got stall=%b count=%0d want 1/1", stall, stall_count);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({stall, pending_any, pc_write} !== 3'b001) begin
      miscompares++;
      $display("FAIL mid_stall_reset: got stall/pend/pcw=%b want 001", {stall, pending_any, pc_write});
    end
    vectors++;
    if (stall_count !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_stall_count: got %0d want 0", stall_count);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 2'd0, 1'b0);
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_stall_after: got stall=%b want 0", stall);
    end
    idle();
    $display("test_reset_mid_stall done");
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mul();
    test_x0();
    test_flush();
    test_waw();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish before 100000 ns");
    $fatal(1, "timeout");
  end

endmodule
